// File: rtl/skeeball_hole_detect.sv
`default_nettype none
// ============================================================================
// Module   : skeeball_hole_detect
// Purpose  : Skeeball lane front end. Synchronises the seven raw hole
//            sensors, debounces them, picks the highest-value hole when
//            several fire, and emits exactly one one-hot hit pulse per ball.
//            A post-hit lockout stops a single ball from being counted twice.
// Ports    : clk         - system clock
//            rst_n       - asynchronous active-low reset
//            game_active - high while a game runs; low forces IDLE
//            hole_raw    - raw sensors {100,50,40,30,20,10,gutter}
//            hit_pulse   - one-cycle one-hot hit, same mapping as hole_raw
//            hit_valid   - OR of hit_pulse
//            busy        - high while in QUALIFY, PULSE or LOCKOUT
//            stuck_err   - per-sensor stuck flags
// Options  : SKEEBALL_STUCK_DETECT_EN - when defined, a sensor held high in
//            LOCKOUT for STUCK_CYCLES is flagged in stuck_err and masked
//            until reset. Undefined: stuck_err is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module skeeball_hole_detect #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned LOCKOUT_CYCLES  = 16,
  parameter int unsigned RELEASE_CYCLES  = 8,
  parameter int unsigned STUCK_CYCLES    = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       game_active,
  input  logic [6:0] hole_raw,
  output logic [6:0] hit_pulse,
  output logic       hit_valid,
  output logic       busy,
  output logic [6:0] stuck_err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUALIFY = 2'd1,
    ST_PULSE   = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  localparam logic [15:0] C_DEBOUNCE = 16'(DEBOUNCE_CYCLES);
  localparam logic [15:0] C_LOCKOUT  = 16'(LOCKOUT_CYCLES);
  localparam logic [15:0] C_RELEASE  = 16'(RELEASE_CYCLES);

  // An out-of-range configuration shows up as this named block in the
  // elaborated hierarchy.
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535 ||
      LOCKOUT_CYCLES  < 1 || LOCKOUT_CYCLES  > 65535 ||
      RELEASE_CYCLES  < 1 || RELEASE_CYCLES  > 65535 ||
      STUCK_CYCLES    < 1 || STUCK_CYCLES    > 65535) begin : g_bad_params
  end

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Highest set bit wins: ascending scan, last assignment survives.
  function automatic logic [6:0] prio_pick(input logic [6:0] v);
    logic [6:0] r;
    r = '0;
    for (int i = 0; i < 7; i++) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  logic [6:0]  sync1_q, sync2_q;
  logic [6:0]  s;
  state_t      state_q, state_d;
  logic [6:0]  cap_q, cap_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] lock_cnt_q, lock_cnt_d;
  logic [15:0] rel_cnt_q, rel_cnt_d;
  logic [6:0]  hit_pulse_q, hit_pulse_d;
  logic        hit_valid_q, hit_valid_d;
  logic        busy_q, busy_d;

`ifdef SKEEBALL_STUCK_DETECT_EN
  localparam logic [15:0] C_STUCK = 16'(STUCK_CYCLES);
  logic [15:0] stuck_cnt_q, stuck_cnt_d;
  logic [6:0]  stuck_err_q, stuck_err_d;
  // Flagged sensors read as zero from here on so LOCKOUT can release.
  assign s         = sync2_q & ~stuck_err_q;
  assign stuck_err = stuck_err_q;
`else
  assign s         = sync2_q;
  assign stuck_err = '0;
`endif

  always_comb begin
    state_d     = state_q;
    cap_d       = cap_q;
    cnt_d       = cnt_q;
    lock_cnt_d  = lock_cnt_q;
    rel_cnt_d   = rel_cnt_q;
    hit_pulse_d = '0;
`ifdef SKEEBALL_STUCK_DETECT_EN
    stuck_cnt_d = stuck_cnt_q;
    stuck_err_d = stuck_err_q;
`endif
    if (!game_active) begin
      state_d    = ST_IDLE;
      cap_d      = '0;
      cnt_d      = '0;
      lock_cnt_d = '0;
      rel_cnt_d  = '0;
`ifdef SKEEBALL_STUCK_DETECT_EN
      stuck_cnt_d = '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (s != '0) begin
            cap_d = s;
            cnt_d = 16'd1;
            if (C_DEBOUNCE == 16'd1) begin
              state_d     = ST_PULSE;
              hit_pulse_d = prio_pick(s);
            end else begin
              state_d = ST_QUALIFY;
            end
          end
        end
        ST_QUALIFY: begin
          if (s == '0) begin
            // A single dropped sample aborts the hit.
            state_d = ST_IDLE;
            cap_d   = '0;
            cnt_d   = '0;
          end else if (s == cap_q) begin
            cnt_d = sat_inc(cnt_q);
            if (cnt_d >= C_DEBOUNCE) begin
              state_d     = ST_PULSE;
              hit_pulse_d = prio_pick(cap_q);
            end
          end else begin
            cap_d = s;
            cnt_d = 16'd1;
          end
        end
        ST_PULSE: begin
          state_d    = ST_LOCKOUT;
          lock_cnt_d = '0;
          rel_cnt_d  = '0;
`ifdef SKEEBALL_STUCK_DETECT_EN
          stuck_cnt_d = '0;
`endif
        end
        default: begin // ST_LOCKOUT
          lock_cnt_d = sat_inc(lock_cnt_q);
          rel_cnt_d  = (s == '0) ? sat_inc(rel_cnt_q) : '0;
`ifdef SKEEBALL_STUCK_DETECT_EN
          if (s != '0) begin
            stuck_cnt_d = sat_inc(stuck_cnt_q);
            if (stuck_cnt_d >= C_STUCK) begin
              stuck_err_d = stuck_err_q | s;
              stuck_cnt_d = '0;
            end
          end
`endif
          if (lock_cnt_d >= C_LOCKOUT && rel_cnt_d >= C_RELEASE) begin
            state_d = ST_IDLE;
          end
        end
      endcase
    end
    hit_valid_d = |hit_pulse_d;
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      state_q     <= ST_IDLE;
      cap_q       <= '0;
      cnt_q       <= '0;
      lock_cnt_q  <= '0;
      rel_cnt_q   <= '0;
      hit_pulse_q <= '0;
      hit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SKEEBALL_STUCK_DETECT_EN
      stuck_cnt_q <= '0;
      stuck_err_q <= '0;
`endif
    end else begin
      sync1_q     <= hole_raw;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cap_q       <= cap_d;
      cnt_q       <= cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      hit_pulse_q <= hit_pulse_d;
      hit_valid_q <= hit_valid_d;
      busy_q      <= busy_d;
`ifdef SKEEBALL_STUCK_DETECT_EN
      stuck_cnt_q <= stuck_cnt_d;
      stuck_err_q <= stuck_err_d;
`endif
    end
  end

  assign hit_pulse = hit_pulse_q;
  assign hit_valid = hit_valid_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_skeeball_hole_detect.sv
`default_nettype none
// ============================================================================
// Module   : tb_skeeball_hole_detect
// Purpose  : Directed self-checking bench for skeeball_hole_detect
//            (DEBOUNCE=4, LOCKOUT=16, RELEASE=8). The stuck-sensor scenario
//            runs when SKEEBALL_STUCK_DETECT_EN is defined (STUCK_CYCLES=50).
// Revision : 1.0 - initial release
// ============================================================================
module tb_skeeball_hole_detect;

`ifdef SKEEBALL_STUCK_DETECT_EN
  localparam int unsigned C_STUCK = 50;
`else
  localparam int unsigned C_STUCK = 1000;
`endif

  logic       clk;
  logic       rst_n;
  logic       game_active;
  logic [6:0] hole_raw;
  logic [6:0] hit_pulse;
  logic       hit_valid;
  logic       busy;
  logic [6:0] stuck_err;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;
  int base;

  skeeball_hole_detect #(
    .DEBOUNCE_CYCLES(4),
    .LOCKOUT_CYCLES (16),
    .RELEASE_CYCLES (8),
    .STUCK_CYCLES   (C_STUCK)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .game_active(game_active),
    .hole_raw   (hole_raw),
    .hit_pulse  (hit_pulse),
    .hit_valid  (hit_valid),
    .busy       (busy),
    .stuck_err  (stuck_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count every pulse cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (hit_valid) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    game_active = 1'b0;
    hole_raw    = '0;
    tick(2);
    chk("rst_pulse", 32'(hit_pulse), 32'h0);
    chk("rst_valid", 32'(hit_valid), 32'h0);
    chk("rst_busy",  32'(busy),      32'h0);
    chk("rst_stuck", 32'(stuck_err), 32'h0);
    rst_n = 1'b1;
    tick(1);

    // Clean single hit on the 30 hole.
    base = pulse_cnt;
    game_active = 1'b1;
    hole_raw    = 7'b0001000;
    tick(5);
    chk("t1_no_early", 32'(hit_valid), 32'h0);
    chk("t1_busy_q",   32'(busy),      32'h1);
    tick(1);
    chk("t1_pulse", 32'(hit_pulse), 32'h08);
    chk("t1_valid", 32'(hit_valid), 32'h1);
    tick(1);
    chk("t1_one_cycle", 32'(hit_pulse), 32'h0);
    tick(13);
    hole_raw = '0;
    tick(9);
    chk("t1_busy_hold", 32'(busy), 32'h1);
    tick(1);
    chk("t1_busy_drop", 32'(busy), 32'h0);
    tick(20);
    chk("t1_count", 32'(pulse_cnt - base), 32'h1);

    // Bounce on the 20 hole: 1,0,1,1,1,1.
    base = pulse_cnt;
    hole_raw = 7'b0000100;
    tick(1);
    hole_raw = '0;
    tick(1);
    hole_raw = 7'b0000100;
    tick(4);
    hole_raw = '0;
    tick(1);
    chk("t2_no_early", 32'(hit_valid), 32'h0);
    tick(1);
    chk("t2_pulse", 32'(hit_pulse), 32'h04);
    tick(30);
    chk("t2_count", 32'(pulse_cnt - base), 32'h1);
    chk("t2_idle",  32'(busy),             32'h0);

    // Two sensors at once: 100 beats 10; 10 during lockout is ignored.
    base = pulse_cnt;
    hole_raw = 7'b1000010;
    tick(6);
    chk("t3_prio", 32'(hit_pulse), 32'h40);
    tick(2);
    hole_raw = 7'b0000010;
    tick(10);
    hole_raw = '0;
    tick(30);
    chk("t3_count", 32'(pulse_cnt - base), 32'h1);

    // game_active dropped mid-QUALIFY.
    base = pulse_cnt;
    hole_raw = 7'b0010000;
    tick(4);
    chk("t5_qual_busy", 32'(busy), 32'h1);
    game_active = 1'b0;
    tick(1);
    chk("t5_busy_off", 32'(busy), 32'h0);
    tick(5);
    hole_raw    = '0;
    game_active = 1'b1;
    tick(5);
    chk("t5_no_pulse", 32'(pulse_cnt - base), 32'h0);

    // game_active dropped on the cycle the pulse would issue.
    hole_raw = 7'b0010000;
    tick(5);
    game_active = 1'b0;
    tick(1);
    chk("t5_same_cycle", 32'(hit_valid), 32'h0);
    hole_raw    = '0;
    game_active = 1'b1;
    tick(5);
    chk("t5_no_pulse2", 32'(pulse_cnt - base), 32'h0);

    // Reset asserted during the PULSE cycle.
    hole_raw = 7'b0000100;
    tick(6);
    chk("t6_pulse", 32'(hit_pulse), 32'h04);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_pulse", 32'(hit_pulse), 32'h0);
    chk("t6_rst_valid", 32'(hit_valid), 32'h0);
    chk("t6_rst_busy",  32'(busy),      32'h0);
    hole_raw = '0;
    tick(1);
    rst_n = 1'b1;
    tick(3);

`ifndef SKEEBALL_STUCK_DETECT_EN
    // Held sensor: stays in LOCKOUT, releases RELEASE cycles after s clears.
    hole_raw = 7'b0100000;
    tick(6);
    chk("t4_pulse", 32'(hit_pulse), 32'h20);
    tick(100);
    chk("t4_held_busy",  32'(busy),      32'h1);
    chk("t4_held_stuck", 32'(stuck_err), 32'h0);
    hole_raw = '0;
    tick(9);
    chk("t4_rel_hold", 32'(busy), 32'h1);
    tick(1);
    chk("t4_rel_idle", 32'(busy), 32'h0);
    hole_raw = 7'b0000001;
    tick(6);
    chk("t4_new_hit", 32'(hit_pulse), 32'h01);
    hole_raw = '0;
    tick(30);
`else
    // Gutter sensor stuck high after its hit.
    hole_raw = 7'b0000001;
    tick(6);
    chk("t7_pulse", 32'(hit_pulse), 32'h01);
    tick(50);
    chk("t7_not_yet", 32'(stuck_err), 32'h0);
    tick(1);
    chk("t7_stuck", 32'(stuck_err), 32'h01);
    tick(7);
    chk("t7_rel_hold", 32'(busy), 32'h1);
    tick(1);
    chk("t7_rel_idle", 32'(busy), 32'h0);
    hole_raw = 7'b0100001;
    tick(6);
    chk("t7_new_hit",    32'(hit_pulse), 32'h20);
    chk("t7_stuck_kept", 32'(stuck_err), 32'h01);
    hole_raw = '0;
    tick(30);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
